// File: rtl/dice_pkg.sv
// Shared dice/craps types and constants for the referee and its helpers.
package dice_pkg;

    localparam int DIE_W = 3;
    localparam int SUM_W = 4;

    localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
    localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

    localparam logic [SUM_W-1:0] NATURAL_7  = 4'd7;
    localparam logic [SUM_W-1:0] NATURAL_11 = 4'd11;
    localparam logic [SUM_W-1:0] CRAPS_2    = 4'd2;
    localparam logic [SUM_W-1:0] CRAPS_3    = 4'd3;
    localparam logic [SUM_W-1:0] CRAPS_12   = 4'd12;

    typedef enum logic [1:0] {
        COMEOUT = 2'd0,
        POINT   = 2'd1,
        WIN     = 2'd2,
        LOSE    = 2'd3
    } game_state_t;

    function automatic logic die_legal(input logic [DIE_W-1:0] d);
        return (d >= DIE_MIN) && (d <= DIE_MAX);
    endfunction

endpackage

// File: rtl/roll_conditioner.sv
// Button conditioner: 2-flop synchroniser, optional debounce, single-cycle rise pulse.
// Debounce is built only when CRAPS_DEBOUNCE_EN is defined.
module roll_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_range_check
        $error("DEBOUNCE_CYCLES out of range 1..65535");
    end

    logic r_sync1;
    logic r_roll_s;
    logic r_roll_d;
    logic w_roll_db;

    // NOTE: every clocked register uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_roll_s <= 1'b0;
        end else begin
            r_sync1  <= i_btn;
            r_roll_s <= r_sync1;
        end
    end

`ifdef CRAPS_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] r_db_cnt;
    logic            r_roll_db;

    // Count mismatching cycles; the level flips on the DEBOUNCE_CYCLES-th one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt  <= '0;
            r_roll_db <= 1'b0;
        end else if (r_roll_s == r_roll_db) begin
            r_db_cnt  <= '0;
        end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db_cnt  <= '0;
            r_roll_db <= r_roll_s;
        end else begin
            r_db_cnt  <= r_db_cnt + 1'b1;
        end
    end

    assign w_roll_db = r_roll_db;
`else
    assign w_roll_db = r_roll_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_roll_d <= 1'b0;
        else     r_roll_d <= w_roll_db;
    end

    assign o_rise = w_roll_db & ~r_roll_d;

endmodule

// File: rtl/craps_referee.sv
// Craps referee: samples the dice on each roll press and tracks come-out/point/win/lose.
// Optional button debounce selected by CRAPS_DEBOUNCE_EN (see roll_conditioner).
module craps_referee
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             roll_btn,
    input  logic             new_game,
    input  logic [DIE_W-1:0] dice1_in,
    input  logic [DIE_W-1:0] dice2_in,
    output logic [DIE_W-1:0] die1_q,
    output logic [DIE_W-1:0] die2_q,
    output logic [SUM_W-1:0] sum_q,
    output logic [SUM_W-1:0] point_q,
    output logic [1:0]       state_q,
    output logic             win,
    output logic             lose,
    output logic             dice_err,
    output logic [CNT_W-1:0] roll_count
);

    game_state_t      r_state, w_next_state;
    logic [SUM_W-1:0] r_point, w_next_point;
    logic [DIE_W-1:0] r_die1, r_die2;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_count;
    logic             r_win, r_lose, r_dice_err;

    logic             w_roll_rise;
    logic             w_in_play;
    logic             w_legal;
    logic             w_accept;
    logic             w_illegal;
    logic [SUM_W-1:0] w_sum;

    roll_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_roll_conditioner (
        .clk   (clk),
        .rst   (rst),
        .i_btn (roll_btn),
        .o_rise(w_roll_rise)
    );

    // new_game swallows any coincident roll, legal or not.
    assign w_in_play = (r_state == COMEOUT) || (r_state == POINT);
    assign w_legal   = die_legal(dice1_in) && die_legal(dice2_in);
    assign w_accept  = w_roll_rise && w_in_play && w_legal && !new_game;
    assign w_illegal = w_roll_rise && w_in_play && !w_legal && !new_game;
    assign w_sum     = SUM_W'(dice1_in) + SUM_W'(dice2_in);

    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_point = r_point;
        if (new_game) begin
            w_next_state = COMEOUT;
            w_next_point = '0;
        end else if (w_accept) begin
            unique case (r_state)
                COMEOUT: begin
                    if (w_sum == NATURAL_7 || w_sum == NATURAL_11) begin
                        w_next_state = WIN;
                    end else if (w_sum == CRAPS_2 || w_sum == CRAPS_3 || w_sum == CRAPS_12) begin
                        w_next_state = LOSE;
                    end else begin
                        w_next_state = POINT;
                        w_next_point = w_sum;
                    end
                end
                POINT: begin
                    if (w_sum == r_point)        w_next_state = WIN;
                    else if (w_sum == NATURAL_7) w_next_state = LOSE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COMEOUT;
            r_point <= '0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_point <= w_next_point;
            r_win   <= (w_next_state == WIN);
            r_lose  <= (w_next_state == LOSE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_die1     <= '0;
            r_die2     <= '0;
            r_sum      <= '0;
            r_count    <= '0;
            r_dice_err <= 1'b0;
        end else begin
            r_dice_err <= w_illegal;
            if (new_game) begin
                r_die1  <= '0;
                r_die2  <= '0;
                r_sum   <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                r_die1 <= dice1_in;
                r_die2 <= dice2_in;
                r_sum  <= w_sum;
                if (r_count != '1) r_count <= r_count + 1'b1;
            end
        end
    end

    assign die1_q     = r_die1;
    assign die2_q     = r_die2;
    assign sum_q      = r_sum;
    assign point_q    = r_point;
    assign state_q    = r_state;
    assign win        = r_win;
    assign lose       = r_lose;
    assign dice_err   = r_dice_err;
    assign roll_count = r_count;

endmodule
